// File: rtl/aes_pkg.sv
// Shared types and constants for the AES word-stream loader.
package aes_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned MSG_W     = 128;
    localparam int unsigned MSG_WORDS = MSG_W / WORD_W;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [2:0] {
        LOAD_KEY,
        LOAD_MSG,
        START,
        ARM,
        WAIT,
        UNLOAD
    } loader_state_t;

    function automatic int unsigned key_words(input int unsigned k);
        return k / WORD_W;
    endfunction

endpackage

// File: rtl/aes_out_serializer.sv
// Holds the 128-bit core result and returns it as four valid/ready words, MS word first.
module aes_out_serializer
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [MSG_W-1:0]  i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data,
    output logic              o_last,
    output logic              o_done_c
);

    logic [MSG_W-1:0]  r_result;
    logic [1:0]        r_idx;
    logic              r_valid;
    logic [WORD_W-1:0] r_data;
    logic              r_last;
    logic              w_xfer;

    assign w_xfer   = r_valid & i_ready;
    assign o_done_c = w_xfer & r_last;
    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_last   = r_last;

    // r_result shifts left so its top word is always the one presented next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_idx    <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_last   <= 1'b0;
        end else if (i_load) begin
            r_result <= i_data;
            r_idx    <= '0;
            r_valid  <= 1'b1;
            r_data   <= i_data[MSG_W-1 -: WORD_W];
            r_last   <= 1'b0;
        end else if (w_xfer) begin
            if (r_last) begin
                r_result <= '0;
                r_idx    <= '0;
                r_valid  <= 1'b0;
                r_data   <= '0;
                r_last   <= 1'b0;
            end else begin
                r_result <= {r_result[MSG_W-WORD_W-1:0], {WORD_W{1'b0}}};
                r_idx    <= r_idx + 2'd1;
                r_data   <= r_result[MSG_W-WORD_W-1 -: WORD_W];
                r_last   <= (r_idx == 2'd2);
            end
        end
    end

endmodule

// File: rtl/aes_word_loader.sv
// Word-stream front end for aes_core: loads key/message, pulses ce, unloads the result.
// Optional AES_KEY_REUSE_EN adds in_reuse to skip the key load when a key is already held.
module aes_word_loader
    import aes_pkg::*;
#(
    parameter int unsigned K = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_dir,
`ifdef AES_KEY_REUSE_EN
    input  logic              in_reuse,
`endif
    output logic              in_ready,
    output logic [K-1:0]      key,
    output logic [MSG_W-1:0]  message,
    output logic              ce,
    output logic              asyncdir,
    input  logic              done2,
    input  logic [MSG_W-1:0]  translated,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
);

    localparam int unsigned    KW       = key_words(K);
    localparam logic [CNT_W-1:0] KW_LAST  = CNT_W'(KW - 1);
    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_WORDS - 1);

    loader_state_t     r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [K-1:0]      r_key;
    logic [MSG_W-1:0]  r_msg;
    logic              r_dir;
    logic              r_ce;
    logic              r_in_ready;
    logic              r_busy;
    logic              w_accept;
    logic              w_key_we;
    logic              w_msg_we;
    logic              w_dir_we;
    logic              w_load;
    logic              w_reuse;
    logic              w_out_done;

`ifdef AES_KEY_REUSE_EN
    logic              r_key_ok;
    assign w_reuse = in_reuse & r_key_ok;
`else
    assign w_reuse = 1'b0;
`endif

    assign w_accept = in_valid & r_in_ready;
    assign in_ready = r_in_ready;
    assign key      = r_key;
    assign message  = r_msg;
    assign ce       = r_ce;
    assign asyncdir = r_dir;
    assign busy     = r_busy;

    // Next state, word counter and register write enables.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_key_we    = 1'b0;
        w_msg_we    = 1'b0;
        w_dir_we    = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            LOAD_KEY: begin
                if (w_accept) begin
                    w_dir_we = (r_cnt == '0);
                    if (r_cnt == '0 && w_reuse) begin
                        // Reused key: this word is already message word 0.
                        w_msg_we    = 1'b1;
                        w_state_nxt = LOAD_MSG;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_key_we = 1'b1;
                        if (r_cnt == KW_LAST) begin
                            w_state_nxt = LOAD_MSG;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            LOAD_MSG: begin
                if (w_accept) begin
                    w_msg_we = 1'b1;
                    if (r_cnt == MSG_LAST) begin
                        w_state_nxt = START;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            START:   w_state_nxt = ARM;
            ARM:     w_state_nxt = WAIT;
            WAIT: begin
                if (done2) begin
                    w_load      = 1'b1;
                    w_state_nxt = UNLOAD;
                end
            end
            UNLOAD: begin
                if (w_out_done) w_state_nxt = LOAD_KEY;
            end
            default: begin
                w_state_nxt = LOAD_KEY;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Key/message shift in MS word first; outputs are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= LOAD_KEY;
            r_cnt      <= '0;
            r_key      <= '0;
            r_msg      <= '0;
            r_dir      <= 1'b0;
            r_ce       <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_key_we) r_key <= {r_key[K-WORD_W-1:0], in_data};
            if (w_msg_we) r_msg <= {r_msg[MSG_W-WORD_W-1:0], in_data};
            if (w_dir_we) r_dir <= in_dir;
            r_ce       <= (w_state_nxt == START);
            r_in_ready <= (w_state_nxt == LOAD_KEY) || (w_state_nxt == LOAD_MSG);
            r_busy     <= !((w_state_nxt == LOAD_KEY) && (w_cnt_nxt == '0));
        end
    end

`ifdef AES_KEY_REUSE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_ok <= 1'b0;
        end else if (w_key_we && r_cnt == KW_LAST) begin
            r_key_ok <= 1'b1;
        end
    end
`endif

    aes_out_serializer u_ser (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_data   (translated),
        .i_ready  (out_ready),
        .o_valid  (out_valid),
        .o_data   (out_data),
        .o_last   (out_last),
        .o_done_c (w_out_done)
    );

endmodule

// File: tb/tb_aes_word_loader.sv
// Bench for aes_word_loader (K=128 and K=256) with a behavioural aes_core stand-in.
// AES_KEY_REUSE_EN selects the key-reuse sequences.
module tb_aes_word_loader;

    localparam int LAT = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         vin_a, vin_b;
    logic [31:0]  in_data;
    logic         in_dir, in_reuse, out_ready;
    logic         sel;

    logic         rdy_a, ce_a, dir_a, ov_a, ol_a, busy_a, done2_a;
    logic [127:0] key_a, msg_a, tr_a;
    logic [31:0]  od_a;
    logic         rdy_b, ce_b, dir_b, ov_b, ol_b, busy_b, done2_b;
    logic [255:0] key_b;
    logic [127:0] msg_b, tr_b;
    logic [31:0]  od_b;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    aes_word_loader #(.K(128)) dut_a (
        .clk(clk), .reset(reset), .in_valid(vin_a), .in_data(in_data), .in_dir(in_dir),
`ifdef AES_KEY_REUSE_EN
        .in_reuse(in_reuse),
`endif
        .in_ready(rdy_a), .key(key_a), .message(msg_a), .ce(ce_a), .asyncdir(dir_a),
        .done2(done2_a), .translated(tr_a), .out_valid(ov_a), .out_data(od_a),
        .out_last(ol_a), .out_ready(out_ready), .busy(busy_a)
    );

    aes_word_loader #(.K(256)) dut_b (
        .clk(clk), .reset(reset), .in_valid(vin_b), .in_data(in_data), .in_dir(in_dir),
`ifdef AES_KEY_REUSE_EN
        .in_reuse(in_reuse),
`endif
        .in_ready(rdy_b), .key(key_b), .message(msg_b), .ce(ce_b), .asyncdir(dir_b),
        .done2(done2_b), .translated(tr_b), .out_valid(ov_b), .out_data(od_b),
        .out_last(ol_b), .out_ready(out_ready), .busy(busy_b)
    );

    wire         w_rdy  = sel ? rdy_b  : rdy_a;
    wire         w_ce   = sel ? ce_b   : ce_a;
    wire         w_dir  = sel ? dir_b  : dir_a;
    wire         w_ov   = sel ? ov_b   : ov_a;
    wire         w_ol   = sel ? ol_b   : ol_a;
    wire         w_busy = sel ? busy_b : busy_a;
    wire [31:0]  w_od   = sel ? od_b   : od_a;
    wire [255:0] w_key  = sel ? key_b  : 256'(key_a);
    wire [127:0] w_msg  = sel ? msg_b  : msg_a;

    // Core stand-in: known FIPS-197 answers, otherwise a simple keyed mix.
    function automatic logic [127:0] core_f(input logic [255:0] k, input logic [127:0] m, input logic d);
        if (k == 256'h000102030405060708090a0b0c0d0e0f && !d && m == 128'h00112233445566778899aabbccddeeff)
            return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        if (k == 256'h000102030405060708090a0b0c0d0e0f && d && m == 128'h69c4e0d86a7b0430d8cdb78070b4c55a)
            return 128'h00112233445566778899aabbccddeeff;
        if (k == 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f && !d &&
            m == 128'h00112233445566778899aabbccddeeff)
            return 128'h8ea2b7ca516745bfeafc49904b496089;
        return m ^ k[127:0] ^ k[255:128] ^ {128{d}};
    endfunction

    // done2 stays high from the previous run until the cycle after ARM.
    logic cd_a, run_a, cd_b, run_b;
    int   cnt_a, cnt_b;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cd_a <= 0; run_a <= 0; cnt_a <= 0; done2_a <= 0; tr_a <= '0;
        end else begin
            cd_a <= ce_a;
            if (cd_a) begin
                done2_a <= 0; run_a <= 1; cnt_a <= LAT;
            end else if (run_a) begin
                if (cnt_a == 0) begin
                    done2_a <= 1; run_a <= 0; tr_a <= core_f(256'(key_a), msg_a, dir_a);
                end else cnt_a <= cnt_a - 1;
            end
        end
    end
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cd_b <= 0; run_b <= 0; cnt_b <= 0; done2_b <= 0; tr_b <= '0;
        end else begin
            cd_b <= ce_b;
            if (cd_b) begin
                done2_b <= 0; run_b <= 1; cnt_b <= LAT;
            end else if (run_b) begin
                if (cnt_b == 0) begin
                    done2_b <= 1; run_b <= 0; tr_b <= core_f(key_b, msg_b, dir_b);
                end else cnt_b <= cnt_b - 1;
            end
        end
    end

    typedef struct {
        logic         sel;
        logic [255:0] key;
        logic [127:0] msg;
        logic         dir;
        logic [127:0] exp;
        int           stall_word;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input logic ok, input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_vin(input logic x);
        if (sel) vin_b = x; else vin_a = x;
    endtask

    task automatic send(input logic [31:0] w);
        int t = 0;
        in_data = w;
        set_vin(1'b1);
        while (!w_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk(w_rdy, "in_ready_timeout", 256'(w_rdy), 256'(1));
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk(rdy_a == 1 && rdy_b == 1, {tag, "_in_ready"}, 256'({rdy_a, rdy_b}), 256'(3));
        chk(ce_a == 0 && ce_b == 0 && dir_a == 0 && dir_b == 0, {tag, "_ce_dir"},
            256'({ce_a, ce_b, dir_a, dir_b}), 256'(0));
        chk(ov_a == 0 && ov_b == 0 && ol_a == 0 && ol_b == 0, {tag, "_out_flags"},
            256'({ov_a, ov_b, ol_a, ol_b}), 256'(0));
        chk(od_a == 0 && od_b == 0, {tag, "_out_data"}, 256'({od_a, od_b}), 256'(0));
        chk(key_a == 0 && key_b == 0 && msg_a == 0 && msg_b == 0, {tag, "_key_msg"},
            key_b | 256'(key_a) | 256'(msg_a) | 256'(msg_b), 256'(0));
        chk(busy_a == 0 && busy_b == 0, {tag, "_busy"}, 256'({busy_a, busy_b}), 256'(0));
    endtask

    task automatic load_words(input vec_t v, input bit msg_only);
        logic [255:0] tmp;
        int kw;
        sel    = v.sel;
        in_dir = v.dir;
        kw     = v.sel ? 8 : 4;
        tmp    = v.sel ? v.key : (v.key << 128);
        if (!msg_only)
            for (int i = 0; i < kw; i++) send(tmp[255-32*i -: 32]);
        for (int j = 0; j < 4; j++) send(v.msg[127-32*j -: 32]);
        set_vin(1'b0);
    endtask

    task automatic recv(input int stall_word);
        logic [31:0] exp;
        for (int n = 0; n < 4; n++) begin
            int t = 0;
            while (!w_ov && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                chk(w_ov, "out_valid_timeout", 256'(w_ov), 256'(1));
                return;
            end
            exp = sb.pop_front();
            chk(w_od == exp, "out_data", 256'(w_od), 256'(exp));
            chk(w_ol == (n == 3), "out_last", 256'(w_ol), 256'(n == 3));
            if (n == stall_word) begin
                out_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    chk(w_od == exp && w_ov, "stall_hold", 256'({w_ov, w_od}), 256'({1'b1, exp}));
                    chk(w_rdy == 0, "stall_in_ready", 256'(w_rdy), 256'(0));
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk(w_ov == 0, "out_valid_clear", 256'(w_ov), 256'(0));
        chk(w_rdy == 1 && w_busy == 0, "idle_after_unload", 256'({w_rdy, w_busy}), 256'(2));
    endtask

    task automatic run_vec(input vec_t v, input bit msg_only);
        load_words(v, msg_only);
        for (int n = 0; n < 4; n++) sb.push_back(v.exp[127-32*n -: 32]);
        chk(w_ce == 1, "ce_pulse", 256'(w_ce), 256'(1));
        chk(w_key == v.key, "key_out", w_key, v.key);
        chk(w_msg == v.msg && w_dir == v.dir, "msg_dir_out", 256'({w_dir, w_msg}), 256'({v.dir, v.msg}));
        chk(w_busy == 1, "busy_run", 256'(w_busy), 256'(1));
        @(negedge clk);
        chk(w_ce == 0 && w_rdy == 0, "ce_single_rdy_low", 256'({w_ce, w_rdy}), 256'(0));
        recv(v.stall_word);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 256'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                   1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1};
        tbl[1] = '{1'b0, 256'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                   1'b1, 128'h00112233445566778899aabbccddeeff, -1};
        tbl[2] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                   128'h00112233445566778899aabbccddeeff, 1'b0, 128'h8ea2b7ca516745bfeafc49904b496089, -1};
        tbl[3] = '{1'b0, 256'hdeadbeef_01234567_89abcdef_cafef00d, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0,
                   1'b1, 128'h0, 3};
        tbl[3].exp = core_f(tbl[3].key, tbl[3].msg, tbl[3].dir);

        reset = 1; vin_a = 0; vin_b = 0; in_data = 0; in_dir = 0; in_reuse = 0;
        out_ready = 1; sel = 0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 0;
        @(negedge clk);

`ifdef AES_KEY_REUSE_EN
        in_reuse = 1'b1;   // no key held yet: must still take a full key load
`endif
        for (int i = 0; i < 4; i++) begin
            run_vec(tbl[i], 1'b0);
            in_reuse = 1'b0;
        end

        // Abort in WAIT with reset, then rerun the first vector.
        load_words(tbl[0], 1'b0);
        repeat (3) @(negedge clk);
        chk(rdy_a == 0 && busy_a == 1, "wait_state", 256'({rdy_a, busy_a}), 256'(1));
        reset = 1;
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        run_vec(tbl[0], 1'b0);

`ifdef AES_KEY_REUSE_EN
        in_reuse = 1'b1;
        run_vec(tbl[0], 1'b1);
        in_reuse = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
